// File: rtl/stream_packer_pkg.sv
// stream_packer shared widths.
// Used by the packer, its lane accumulator and its interfaces.
package stream_packer_pkg;

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_packer_if.sv
// Valid/ready bundles for the packer: narrow beats in, wide words out.
// The narrow side carries a last marker, the wide side a lane count.
interface stream_packer_in_if #(
  parameter int DATAW = 8
) ();
  logic             valid;
  logic             ready;
  logic             last;
  logic [DATAW-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

interface stream_packer_out_if
  import stream_packer_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int RATIO = 4
) ();
  logic                     valid;
  logic                     ready;
  logic [RATIO*DATAW-1:0]   data;
  logic [cnt_w(RATIO)-1:0]  count;

  modport master (output valid, data, count, input ready);
  modport slave  (input valid, data, count, output ready);
endinterface

// File: rtl/stream_packer_lane_acc.sv
// Lane counter and assembly register for stream_packer.
// STREAM_PACKER_FLUSH_EN lets last_in close a partial word.
module stream_packer_lane_acc
  import stream_packer_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int RATIO = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc_en,
  input  logic [DATAW-1:0]        data_in,
  input  logic                    last_in,
  output logic                    completing,
  output logic [RATIO*DATAW-1:0]  word,
  output logic [cnt_w(RATIO)-1:0] fill
);

  localparam int IW = idx_w(RATIO);
  localparam int CW = cnt_w(RATIO);

  logic flush_hit;

`ifdef STREAM_PACKER_FLUSH_EN
  assign flush_hit = last_in;
`else
  logic unused_last;
  assign unused_last = last_in;
  assign flush_hit   = 1'b0;
`endif

  if (RATIO == 1) begin : g_pipe
    logic unused_pipe;
    assign unused_pipe = ^{clk, reset, acc_en, flush_hit};
    assign completing  = 1'b1;
    assign word        = data_in;
    assign fill        = CW'(1);
  end else begin : g_acc
    logic [IW-1:0]              cnt_q, cnt_d;
    logic [(RATIO-1)*DATAW-1:0] asm_q, asm_d;

    assign completing = (cnt_q == IW'(RATIO - 1)) || flush_hit;
    assign fill       = CW'(cnt_q) + CW'(1);

    // Lanes above cnt are always zero in asm_q
    always_comb begin
      word = {{DATAW{1'b0}}, asm_q};
      for (int i = 0; i < RATIO; i++) begin
        if (cnt_q == IW'(i)) word[i*DATAW +: DATAW] = data_in;
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      asm_d = asm_q;
      if (acc_en) begin
        if (completing) begin
          cnt_d = '0;
          asm_d = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
          for (int i = 0; i < RATIO - 1; i++) begin
            if (cnt_q == IW'(i)) asm_d[i*DATAW +: DATAW] = data_in;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        asm_q <= asm_d;
      end
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer with a registered wide output.
// STREAM_PACKER_FLUSH_EN enables early close of a word on last.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int RATIO = 4
) (
  input  logic               clk,
  input  logic               reset,
  stream_packer_in_if.slave  in_if,
  stream_packer_out_if.master out_if
);

  localparam int CW = cnt_w(RATIO);
  localparam int WW = RATIO * DATAW;

  logic          completing;
  logic [WW-1:0] word;
  logic [CW-1:0] fill;
  logic          stall;
  logic          acc;

  logic          valid_q, valid_d;
  logic [WW-1:0] data_q,  data_d;
  logic [CW-1:0] count_q, count_d;

  // Only the completing beat waits on a blocked output
  assign stall       = valid_q && !out_if.ready;
  assign in_if.ready = reset && (!stall || !completing);
  assign acc         = in_if.valid && in_if.ready;

  stream_packer_lane_acc #(
    .DATAW (DATAW),
    .RATIO (RATIO)
  ) u_lane_acc (
    .clk        (clk),
    .reset      (reset),
    .acc_en     (acc),
    .data_in    (in_if.data),
    .last_in    (in_if.last),
    .completing (completing),
    .word       (word),
    .fill       (fill)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (acc && completing) begin
      valid_d = 1'b1;
      data_d  = word;
      count_d = fill;
    end else if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.count = count_q;

endmodule

// File: tb/tb_stream_packer.sv
// Randomized bench for stream_packer (RATIO 4 and RATIO 1) against
// a beat-queue reference model.
module tb_stream_packer;

  localparam int DW = 8;
  localparam int R  = 4;
`ifdef STREAM_PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_packer_in_if  #(.DATAW(DW))            a_in ();
  stream_packer_out_if #(.DATAW(DW), .RATIO(R)) a_out ();
  stream_packer_in_if  #(.DATAW(DW))            b_in ();
  stream_packer_out_if #(.DATAW(DW), .RATIO(1)) b_out ();

  stream_packer #(.DATAW(DW), .RATIO(R)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_if  (a_in),
    .out_if (a_out)
  );

  stream_packer #(.DATAW(DW), .RATIO(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .in_if  (b_in),
    .out_if (b_out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  parts[$];
  logic        m_valid;
  logic [31:0] m_data;
  int          m_count;
  logic        b_valid;
  logic [7:0]  b_data;
  int          b_count;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    parts.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_count = 0;
    b_valid = 1'b0;
    b_data  = '0;
    b_count = 0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d,
                       input logic l, input logic ro, input logic ro1);
    logic comp, rdy, rdy1;
    a_in.valid  = v;
    a_in.data   = d;
    a_in.last   = l;
    a_out.ready = ro;
    b_in.valid  = v;
    b_in.data   = d;
    b_in.last   = l;
    b_out.ready = ro1;
    @(negedge clk);
    comp = (parts.size() == R - 1) || (FLUSH && l);
    rdy  = !(m_valid && !ro && comp);
    rdy1 = !(b_valid && !ro1);
    check("a_rdy",  64'(a_in.ready),  64'(rdy));
    check("a_vld",  64'(a_out.valid), 64'(m_valid));
    check("a_data", 64'(a_out.data),  64'(m_data));
    check("a_cnt",  64'(a_out.count), 64'(m_count));
    check("b_rdy",  64'(b_in.ready),  64'(rdy1));
    check("b_vld",  64'(b_out.valid), 64'(b_valid));
    check("b_data", 64'(b_out.data),  64'(b_data));
    check("b_cnt",  64'(b_out.count), 64'(b_count));
    if (v && rdy) parts.push_back(d);
    if (v && rdy && comp) begin
      m_data = '0;
      foreach (parts[i]) m_data[i*8 +: 8] = parts[i];
      m_count = parts.size();
      m_valid = 1'b1;
      parts.delete();
    end else if (m_valid && ro) begin
      m_valid = 1'b0;
    end
    if (v && rdy1) begin
      b_valid = 1'b1;
      b_data  = d;
      b_count = 1;
    end else if (b_valid && ro1) begin
      b_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_in.valid = 1'b0;
    b_in.valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_vld",  64'(a_out.valid), 64'(0));
    check("rst_cnt",  64'(a_out.count), 64'(0));
    check("rst_data", 64'(a_out.data),  64'(0));
    check("rst_rdy",  64'(a_in.ready),  64'(0));
    check("rst_rdy1", 64'(b_in.ready),  64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in.valid = 0; a_in.data = 0; a_in.last = 0; a_out.ready = 0;
    b_in.valid = 0; b_in.data = 0; b_in.last = 0; b_out.ready = 0;
    reset = 1'b1;
    #2;
    do_reset();

    // full word
    cycle(1, 8'h11, 0, 1, 1);
    cycle(1, 8'h22, 0, 1, 1);
    cycle(1, 8'h33, 0, 1, 1);
    cycle(1, 8'h44, 0, 1, 1);
    check("full_data", 64'(a_out.data),  64'(32'h44332211));
    check("full_cnt",  64'(a_out.count), 64'(4));
    check("full_vld",  64'(a_out.valid), 64'(1));
    cycle(0, 8'h00, 0, 1, 1);

    // back-to-back
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'hA0 + i), 0, 1, 1);
    check("b2b_data", 64'(a_out.data), 64'(32'hA7A6A5A4));
    cycle(0, 8'h00, 0, 1, 1);

    // backpressure
    for (int i = 1; i <= 7; i++) cycle(1, 8'(i), 0, 0, 1);
    cycle(1, 8'h08, 0, 0, 1);
    cycle(1, 8'h08, 0, 0, 1);
    cycle(1, 8'h08, 0, 1, 1);
    check("bp_data", 64'(a_out.data),  64'(32'h08070605));
    check("bp_vld",  64'(a_out.valid), 64'(1));
    cycle(0, 8'h00, 0, 1, 1);

`ifdef STREAM_PACKER_FLUSH_EN
    cycle(1, 8'hAA, 0, 1, 1);
    cycle(1, 8'hBB, 1, 1, 1);
    check("fl_data", 64'(a_out.data),  64'(32'h0000BBAA));
    check("fl_cnt",  64'(a_out.count), 64'(2));
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hC0 + i), 0, 1, 1);
    check("fl_next", 64'(a_out.data), 64'(32'hC3C2C1C0));
`endif

    // reset mid-packet
    cycle(1, 8'hE1, 0, 1, 1);
    cycle(1, 8'hE2, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h31 + i), 0, 1, 1);
    check("rst_word", 64'(a_out.data), 64'(32'h34333231));
    cycle(0, 8'h00, 0, 1, 1);

    // RATIO=1 with toggling downstream ready
    cycle(1, 8'h5A, 0, 1, 0);
    cycle(1, 8'hC3, 0, 1, 1);
    cycle(1, 8'hC3, 0, 1, 0);
    cycle(0, 8'h00, 0, 1, 1);
    cycle(0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom),
            ($urandom % 5) == 0, ($urandom % 3) != 0,
            1'($urandom % 2));
    end
    for (int i = 0; i < 6; i++) cycle(0, 8'h00, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
